// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: the two requester ports, the shared
// memory port and the grant select. The "slave" modport is the arbiter's
// view; the "master" modport is the surrounding core/memory view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Port 0: instruction fetch (read only)
    logic              m0_req;
    logic [ADDR_W-1:0] m0_addr;
    logic              m0_ready;
    logic              m0_rvalid;
    logic [DATA_W-1:0] m0_rdata;

    // Port 1: load/store
    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_ready;
    logic              m1_rvalid;
    logic [DATA_W-1:0] m1_rdata;

    // Shared memory port
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    // Current grant, drives the shared address/write-data muxes
    logic              sel;

    modport slave (
        input  m0_req, m0_addr,
        output m0_ready, m0_rvalid, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_ready, m1_rvalid, m1_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rvalid, mem_rdata,
        output sel
    );

    modport master (
        output m0_req, m0_addr,
        input  m0_ready, m0_rvalid, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_ready, m1_rvalid, m1_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rvalid, mem_rdata,
        input  sel
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch
// (port 0) and load/store (port 1). One transaction outstanding at a time;
// the winning request is latched at grant and sequenced IDLE->ISSUE->WAIT.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin contention
// resolution; otherwise port 1 has fixed priority.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    mem_port_arbiter_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t            state;
    logic              sel_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              m0_rvalid_q;
    logic              m1_rvalid_q;
    logic [DATA_W-1:0] m0_rdata_q;
    logic [DATA_W-1:0] m1_rdata_q;
    logic              winner;

`ifdef ARB_ROUND_ROBIN_EN
    // Port granted most recently; starts at 1 so port 0 wins first contention.
    logic              last_sel;

    // Pick the winner: on contention the port not granted last.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        winner = bus.m1_req;
        if (bus.m0_req && bus.m1_req) begin
            winner = ~last_sel;
        end
    end

    // Remember the last grant for round-robin fairness.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_sel <= 1'b1;
        end else if (state == IDLE && (bus.m0_req || bus.m1_req)) begin
            last_sel <= winner;
        end
    end
`else
    // Pick the winner: port 1 (load/store) wins any contention.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        winner = bus.m1_req;
    end
`endif

    // Transaction sequencer: latch the grant, hold the memory request until
    // ack, then capture the response and pulse rvalid to the owner.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rstn) begin
            state       <= IDLE;
            sel_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
        end else begin
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.m0_req || bus.m1_req) begin
                        sel_q     <= winner;
                        mem_req_q <= 1'b1;
                        if (winner) begin
                            mem_we_q    <= bus.m1_we;
                            mem_addr_q  <= bus.m1_addr;
                            mem_wdata_q <= bus.m1_wdata;
                        end else begin
                            mem_we_q    <= 1'b0;
                            mem_addr_q  <= bus.m0_addr;
                            mem_wdata_q <= '0;
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.mem_ack) begin
                        mem_req_q <= 1'b0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.mem_rvalid) begin
                        if (sel_q) begin
                            m1_rvalid_q <= 1'b1;
                            m1_rdata_q  <= bus.mem_rdata;
                        end else begin
                            m0_rvalid_q <= 1'b1;
                            m0_rdata_q  <= bus.mem_rdata;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Ready is combinational on the ack cycle so the requester sees it at once.
    assign bus.m0_ready  = (state == ISSUE) && bus.mem_ack && !sel_q;
    assign bus.m1_ready  = (state == ISSUE) && bus.mem_ack &&  sel_q;

    assign bus.m0_rvalid = m0_rvalid_q;
    assign bus.m0_rdata  = m0_rdata_q;
    assign bus.m1_rvalid = m1_rvalid_q;
    assign bus.m1_rdata  = m1_rdata_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.sel       = sel_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter. Inputs change 1 ns after the
// rising edge; outputs are checked on the falling edge.
module tb_mem_port_arbiter;

    logic clk;
    logic rstn;
    int   errors;
    int   checks;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Move to the falling edge of the current cycle for checking.
    task automatic mid();
        @(negedge clk);
    endtask

    logic exp_sel [4];

    initial begin
        errors = 0;
        checks = 0;
        rstn   = 1'b0;
        bus.m0_req = 1'b0; bus.m0_addr = '0;
        bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;
        bus.mem_ack = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
`ifdef ARB_ROUND_ROBIN_EN
        exp_sel[0] = 1'b0; exp_sel[1] = 1'b1; exp_sel[2] = 1'b0; exp_sel[3] = 1'b1;
`else
        exp_sel[0] = 1'b1; exp_sel[1] = 1'b1; exp_sel[2] = 1'b1; exp_sel[3] = 1'b1;
`endif

        // ---------------- reset values
        cyc(); cyc();
        mid();
        check("rst_mem_req",  32'(bus.mem_req), 0);
        check("rst_mem_we",   32'(bus.mem_we), 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_wdata",    bus.mem_wdata, 0);
        check("rst_sel",      32'(bus.sel), 0);
        check("rst_rvalid",   32'({bus.m0_rvalid, bus.m1_rvalid, bus.m0_ready, bus.m1_ready}), 0);
        check("rst_rdata",    bus.m0_rdata | bus.m1_rdata, 0);
        cyc(); rstn = 1'b1;

        // ---------------- single fetch, zero-wait memory
        cyc(); bus.m0_req = 1'b1; bus.m0_addr = 32'h100;
        mid(); check("f_req_n", 32'(bus.mem_req), 0);
        cyc(); bus.mem_ack = 1'b1;
        mid();
        check("f_mem_req", 32'(bus.mem_req), 1);
        check("f_sel",     32'(bus.sel), 0);
        check("f_addr",    bus.mem_addr, 32'h100);
        check("f_we",      32'(bus.mem_we), 0);
        check("f_ready",   32'(bus.m0_ready), 1);
        check("f_rv_early", 32'(bus.m0_rvalid), 0);
        cyc(); bus.m0_req = 1'b0; bus.mem_ack = 1'b0;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
        mid();
        check("f_ready_off", 32'(bus.m0_ready), 0);
        check("f_req_off",   32'(bus.mem_req), 0);
        cyc(); bus.mem_rvalid = 1'b0;
        mid();
        check("f_rvalid", 32'(bus.m0_rvalid), 1);
        check("f_rdata",  bus.m0_rdata, 32'hDEADBEEF);
        check("f_m1_rv",  32'(bus.m1_rvalid), 0);
        cyc();
        mid(); check("f_rv_pulse", 32'(bus.m0_rvalid), 0);

        // ---------------- store with ack delayed 4 cycles
        bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 32'h2000; bus.m1_wdata = 32'h12345678;
        cyc();
        for (int i = 0; i < 4; i++) begin
            mid();
            check("s_hold_req",   32'(bus.mem_req), 1);
            check("s_hold_addr",  bus.mem_addr, 32'h2000);
            check("s_hold_wdata", bus.mem_wdata, 32'h12345678);
            check("s_hold_we",    32'(bus.mem_we), 1);
            check("s_no_ready",   32'(bus.m1_ready), 0);
            cyc();
        end
        bus.mem_ack = 1'b1;
        mid();
        check("s_req5",   32'(bus.mem_req), 1);
        check("s_sel",    32'(bus.sel), 1);
        check("s_ready",  32'(bus.m1_ready), 1);
        check("s_m0_rdy", 32'(bus.m0_ready), 0);
        cyc(); bus.mem_ack = 1'b0; bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.mem_rvalid = 1'b1;
        mid(); check("s_ready_off", 32'(bus.m1_ready), 0);
        cyc(); bus.mem_rvalid = 1'b0;
        mid();
        check("s_rvalid", 32'(bus.m1_rvalid), 1);
        check("s_m0_rv",  32'(bus.m0_rvalid), 0);
        cyc();
        mid(); check("s_rv_pulse", 32'(bus.m1_rvalid), 0);

        // ---------------- contention, both requests held for 4 transactions
        bus.m0_req = 1'b1; bus.m0_addr = 32'hA0;
        bus.m1_req = 1'b1; bus.m1_addr = 32'hB0;
        for (int i = 0; i < 4; i++) begin
            cyc(); bus.mem_ack = 1'b1;
            mid();
            check("c_sel",   32'(bus.sel), 32'(exp_sel[i]));
            check("c_addr",  bus.mem_addr, exp_sel[i] ? 32'hB0 : 32'hA0);
            check("c_ready", 32'({bus.m1_ready, bus.m0_ready}), exp_sel[i] ? 2 : 1);
            cyc(); bus.mem_ack = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'(i + 1);
            cyc(); bus.mem_rvalid = 1'b0;
            if (i == 3) begin
                bus.m0_req = 1'b0;
                bus.m1_req = 1'b0;
            end
            mid();
            check("c_rvalid", 32'({bus.m1_rvalid, bus.m0_rvalid}), exp_sel[i] ? 2 : 1);
            check("c_rdata",  exp_sel[i] ? bus.m1_rdata : bus.m0_rdata, 32'(i + 1));
        end
        cyc();
        mid(); check("c_idle", 32'(bus.mem_req), 0);

        // ---------------- fields latched at grant, dropped req does not cancel
        bus.m1_req = 1'b1; bus.m1_addr = 32'h40;
        cyc(); bus.m1_addr = 32'h80; bus.m1_req = 1'b0;
        mid();
        check("l_req",  32'(bus.mem_req), 1);
        check("l_addr", bus.mem_addr, 32'h40);
        cyc(); bus.mem_ack = 1'b1;
        mid();
        check("l_addr_ack", bus.mem_addr, 32'h40);
        check("l_ready",    32'(bus.m1_ready), 1);
        cyc(); bus.mem_ack = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hCAFEF00D;
        cyc(); bus.mem_rvalid = 1'b0;
        mid();
        check("l_rvalid", 32'(bus.m1_rvalid), 1);
        check("l_rdata",  bus.m1_rdata, 32'hCAFEF00D);
        cyc();
        mid();
        check("l_rv_once", 32'(bus.m1_rvalid), 0);
        check("l_no_req",  32'(bus.mem_req), 0);

        // ---------------- reset while in WAIT, late mem_rvalid ignored
        bus.m1_req = 1'b1; bus.m1_addr = 32'h300;
        cyc(); bus.mem_ack = 1'b1;
        cyc(); bus.mem_ack = 1'b0; bus.m1_req = 1'b0;
        mid(); check("r_sel_pre", 32'(bus.sel), 1);
        rstn = 1'b0;
        #1;
        check("r_mem_req", 32'(bus.mem_req), 0);
        check("r_addr",    bus.mem_addr, 0);
        check("r_sel",     32'(bus.sel), 0);
        check("r_rdata",   bus.m1_rdata | bus.m0_rdata, 0);
        cyc(); rstn = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h5555;
        cyc(); bus.mem_rvalid = 1'b0;
        mid();
        check("r_no_rv",   32'({bus.m0_rvalid, bus.m1_rvalid}), 0);
        check("r_rdata2",  bus.m1_rdata | bus.m0_rdata, 0);
        check("r_no_req",  32'(bus.mem_req), 0);
        // next request served normally
        bus.m0_req = 1'b1; bus.m0_addr = 32'h400;
        cyc(); bus.mem_ack = 1'b1;
        mid();
        check("r2_addr",  bus.mem_addr, 32'h400);
        check("r2_ready", 32'(bus.m0_ready), 1);
        cyc(); bus.m0_req = 1'b0; bus.mem_ack = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0BADF00D;
        cyc(); bus.mem_rvalid = 1'b0;
        mid();
        check("r2_rvalid", 32'(bus.m0_rvalid), 1);
        check("r2_rdata",  bus.m0_rdata, 32'h0BADF00D);

        // ---------------- spurious mem_rvalid in IDLE
        cyc(); bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h77;
        mid(); check("sp_req", 32'(bus.mem_req), 0);
        cyc(); bus.mem_rvalid = 1'b0;
        mid();
        check("sp_rv",    32'({bus.m0_rvalid, bus.m1_rvalid}), 0);
        check("sp_rdata", bus.m0_rdata, 32'h0BADF00D);

        // ---------------- spurious mem_ack in WAIT
        bus.m0_req = 1'b1; bus.m0_addr = 32'h500;
        cyc(); bus.mem_ack = 1'b1;
        cyc(); bus.mem_ack = 1'b1; bus.m0_req = 1'b0;
        mid();
        check("sa_ready", 32'({bus.m0_ready, bus.m1_ready}), 0);
        check("sa_req",   32'(bus.mem_req), 0);
        cyc(); bus.mem_ack = 1'b0;
        mid();
        check("sa_rv", 32'({bus.m0_rvalid, bus.m1_rvalid}), 0);
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h600D;
        cyc(); bus.mem_rvalid = 1'b0;
        mid();
        check("sa_rvalid", 32'(bus.m0_rvalid), 1);
        check("sa_rdata",  bus.m0_rdata, 32'h600D);

        cyc(); cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the core's single 32-bit memory port between instruction fetch (port 0) and load/store (port 1). It latches the winning request, drives the grant select for the shared address/write-data muxes, sequences the memory handshake, and routes the response back to the owner. One transaction is outstanding at a time. The block sits between the fetch/MEM stages and the memory interface.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `clk` in 1: core clock; all state on rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `m0_req` in 1: fetch read request; held with `m0_addr` until `m0_ready`.
- `m0_addr` in ADDR_W: fetch address.
- `m0_ready` out 1: one-cycle pulse when the memory accepts the port-0 request.
- `m0_rvalid` out 1: one-cycle pulse with fetch data.
- `m0_rdata` out DATA_W: fetch data; valid while `m0_rvalid`.
- `m1_req`, `m1_we`, `m1_addr`, `m1_wdata` in 1/1/ADDR_W/DATA_W: load/store request, write enable, address, store data.
- `m1_ready`, `m1_rvalid` out 1: as for port 0; `m1_rvalid` also pulses on store completion.
- `m1_rdata` out DATA_W: load data.
- `mem_req` out 1: request to memory; held until `mem_ack`.
- `mem_we`, `mem_addr`, `mem_wdata` out 1/ADDR_W/DATA_W: latched request fields.
- `mem_ack` in 1: memory accepts request this cycle.
- `mem_rvalid` in 1: response/write-completion pulse.
- `mem_rdata` in DATA_W: read data.
- `sel` out 1: current grant, 0 = port 0, 1 = port 1; drives the shared 2:1 muxes.

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE: if any `mX_req`, pick winner, latch `sel`, addr, we (0 for port 0), wdata; go ISSUE. Else stay.
- ISSUE: `mem_req`=1 with latched fields. On `mem_ack`: `m<sel>_ready`=1 combinationally that cycle; go WAIT.
- WAIT: on `mem_rvalid`: latch `mem_rdata`; next cycle `m<sel>_rvalid`=1 with data, go IDLE.
- Contention (both req in IDLE): resolved by policy (see Configuration).
- Fields are latched at grant; requester changes after grant have no effect. A requester dropping `req` after grant does not cancel: the transaction completes and the response pulse is still delivered.
- `mem_rvalid` outside WAIT is ignored. `mem_ack` outside ISSUE is ignored.
- `sel` holds its value through IDLE until the next grant.
- Reset values: state IDLE; `mem_req`, `mem_we`, all `ready`/`rvalid` 0; `mem_addr`, `mem_wdata`, `mX_rdata` 0; `sel` 0.
- Reset mid-transaction: immediately IDLE with reset values; late `mem_rvalid` after reset is ignored.

## Timing
- Request sampled in IDLE at cycle n -> `mem_req` high at n+1.
- `mem_ack` at cycle k -> `ready` pulse at k, WAIT from k+1.
- `mem_rvalid` at cycle r -> `rvalid`/`rdata` at r+1, state IDLE at r+1; a new request may be sampled at r+1.
- Minimum period with a zero-wait memory (ack at n+1, rvalid at n+2): 3 cycles per transaction.
- `ready` and `rvalid` are exactly one cycle wide; never both high for the same port in one cycle.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: round-robin; on contention the port not granted last wins; last-grant register resets to 1 so port 0 wins the first contention after reset.
- Undefined: fixed priority; port 1 (load/store) always wins contention.
- Uncontended requests are granted identically in both builds.

## Test plan
- Single fetch: `m0_addr`=0x100, memory acks at once, returns 0xDEADBEEF next cycle -> `sel`=0, `mem_addr`=0x100, `m0_ready` then `m0_rvalid` with 0xDEADBEEF, total 3 cycles.
- Store: `m1_we`=1, addr 0x2000, wdata 0x12345678, `mem_ack` delayed 4 cycles -> `mem_req` held 5 cycles with stable fields, `m1_ready` on ack cycle, `m1_rvalid` after completion.
- Contention, both req held continuously for 4 transactions -> fixed build: 1,1,1,1; round-robin build: 0,1,0,1 on `sel`.
- Requester changes `m1_addr` from 0x40 to 0x80 and drops `req` after grant -> memory still sees 0x40, `m1_rvalid` still pulses once.
- `rstn` low in WAIT, then `mem_rvalid` after release -> no `rvalid` on either port, all outputs at reset values, next request served normally.
- Spurious `mem_rvalid` in IDLE, `mem_ack` in WAIT -> no output pulses, state unchanged.
